idft_sym_sched: RTL and testbench
=================================

IDFT_SYM_SCHED -- requirements
Module: idft_sym_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the symbol FIFO depth in entries; it must be a power of 2, from 2 to 16.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-004 Port i_rx_started, input, 1 bit, SHALL be a one-cycle pulse from slip_rx marking a frame start.
REQ-005 Port i_rx_byte_done, input, 1 bit, SHALL be a one-cycle pulse from slip_rx qualifying i_rx_byte.
REQ-006 Port i_rx_byte, input, 8 bits, SHALL carry the decoded SLIP payload byte.
REQ-007 Port i_rx_ended, input, 1 bit, SHALL be a one-cycle pulse from slip_rx marking a frame end.
REQ-008 Port i_next_req, input, 1 bit, SHALL be the p_to_s_no_cp o_next_req symbol-boundary pulse.
REQ-009 Port o_start, output, 1 bit, SHALL be the start pulse to p_to_s_no_cp i_start.
REQ-010 Ports o_bin0, o_vc and o_bin1, outputs, 10 bits each, SHALL drive the IDFT bins: o_bin0 to X14/X114, o_vc to X16/X112, o_bin1 to X18/X110.
REQ-011 Port o_level, output, $clog2(DEPTH)+1 bits, SHALL give the current FIFO occupancy.
REQ-012 Ports o_frame_err, o_overflow and o_underrun, outputs, 1 bit each, SHALL be one-cycle event pulses.

Function
REQ-013 The state machine SHALL have states INIT, WAIT_FRAME, COLLECT and COMMIT.
- INIT lasts one cycle, asserts o_start for exactly that cycle, then goes to WAIT_FRAME.
REQ-014 In WAIT_FRAME, i_rx_started SHALL clear the byte counter and move to COLLECT.
REQ-015 In COLLECT, each i_rx_byte_done SHALL store the byte at index cnt (0..5) and increment cnt.
- A 7th or later byte sets a sticky per-frame error bit and is not stored.
REQ-016 In COLLECT, i_rx_ended SHALL go to COMMIT if cnt==6 and the error bit is clear.
- Otherwise it pulses o_frame_err and returns to WAIT_FRAME.
REQ-017 i_rx_started received in COLLECT SHALL discard the partial frame, pulse o_frame_err and restart COLLECT with cnt=0.
REQ-018 COMMIT SHALL last one cycle and push the entry {b1[1:0],b0 ; b3[1:0],b2 ; b5[1:0],b4} as (bin0 ; vc ; bin1); it then returns to WAIT_FRAME.
- Bits [7:2] of the odd-indexed bytes are ignored.
REQ-019 A push while o_level==DEPTH SHALL drop the entry, pulse o_overflow and leave the FIFO unchanged.
REQ-020 i_next_req with o_level>0 SHALL pop the head entry onto o_bin0/o_vc/o_bin1 at the next clock edge (1-cycle latency).
- Outputs then hold until the next pop.
REQ-021 i_next_req with o_level==0 SHALL pulse o_underrun; output behaviour is set by REQ-028/029.
REQ-022 A push and a pop in the same cycle SHALL both be performed.
- If the FIFO is non-empty, o_level is unchanged.
- If the FIFO is empty, the pop is an underrun (no bypass) and o_level becomes 1.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH.
- o_level SHALL reach DEPTH without aliasing.
REQ-024 i_rx_byte_done and i_rx_ended in the same cycle SHALL store the byte first, then evaluate the end condition with the updated cnt.

Reset
REQ-025 While reset is low, the block SHALL clear state to INIT, FIFO pointers, o_level, cnt and the error bit, and drive o_bin0/o_vc/o_bin1 to 0 and all pulse outputs to 0.
REQ-026 Reset asserted mid-frame or mid-symbol SHALL discard all buffered data.
- After release, INIT re-issues o_start on the first clock edge.

Configuration
REQ-027 Macro IDFT_SYM_SCHED_IDLE_ZERO_EN SHALL select the underrun output behaviour.
REQ-028 With IDFT_SYM_SCHED_IDLE_ZERO_EN defined, an underrun SHALL drive o_bin0, o_vc and o_bin1 to 0 at the next edge (idle carrier-off symbol).
REQ-029 Without IDFT_SYM_SCHED_IDLE_ZERO_EN, an underrun SHALL leave o_bin0, o_vc and o_bin1 holding their last values.

Verification
REQ-030 Release reset -> o_start is high for exactly 1 cycle; outputs are 0; o_level=0.
REQ-031 Frame 34,01,78,02,BC,03 then i_next_req -> next cycle o_bin0=134h, o_vc=278h, o_bin1=3BCh; o_level goes 1->0.
REQ-032 Frames of 5 and 7 bytes, and a restart mid-frame -> o_frame_err pulses 3 times; o_level stays 0.
REQ-033 DEPTH=4, 5 valid frames with no pops -> o_level=4, one o_overflow pulse; 4 pops return frames 1-4 in order.
REQ-034 i_next_req on an empty FIFO after one pop of 134h/278h/3BCh -> o_underrun pulses; outputs read 0 with the macro defined, and hold 134h/278h/3BCh without it.
REQ-035 Reset asserted during a 3-byte partial frame with o_level=2 -> all cleared; the next valid frame pops correctly.

Source files
------------

// File: rtl/idft_sym_sched.sv
// idft_sym_sched: collects 6-byte SLIP frames into 3x10-bit IDFT bin entries, queues them, pops one per symbol boundary.
// Ports: clk, reset (async active-low); i_rx_started/i_rx_byte_done/i_rx_byte/i_rx_ended from slip_rx;
// i_next_req symbol-boundary pop request; o_start start pulse; o_bin0/o_vc/o_bin1 bin values;
// o_level FIFO occupancy; o_frame_err/o_overflow/o_underrun event pulses.
// Macro IDFT_SYM_SCHED_IDLE_ZERO_EN: underrun drives bins to 0 (otherwise they hold last values).
module idft_sym_sched #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rx_started,
    input  logic                    i_rx_byte_done,
    input  logic [7:0]              i_rx_byte,
    input  logic                    i_rx_ended,
    input  logic                    i_next_req,
    output logic                    o_start,
    output logic [9:0]              o_bin0,
    output logic [9:0]              o_vc,
    output logic [9:0]              o_bin1,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_frame_err,
    output logic                    o_overflow,
    output logic                    o_underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {INIT, WAIT_FRAME, COLLECT, COMMIT} state_t;
    state_t state, state_n;
    logic [2:0] cnt, cnt_upd;
    logic err, err_upd, frame_err_n;
    logic [29:0] acc;
    logic [29:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0] base;
    logic collect_byte, store, restart, push, full, empty, push_ok, pop_ok;
    assign collect_byte = state == COLLECT && i_rx_byte_done && !i_rx_started;
    assign store = collect_byte && cnt < 3'd6;
    assign cnt_upd = cnt + 3'(store);
    assign err_upd = err | (collect_byte && !store);
    assign restart = i_rx_started && (state == WAIT_FRAME || state == COLLECT);
    assign push = state == COMMIT;
    assign full = o_level == LW'(DEPTH);
    assign empty = o_level == '0;
    assign push_ok = push && !full;
    assign pop_ok = i_next_req && !empty;
    // byte k lands in field k/2: even bytes fill bits [7:0], odd bytes bits [9:8]
    assign base = cnt[2:1] == 2'd0 ? 5'd20 : cnt[2:1] == 2'd1 ? 5'd10 : 5'd0;
    always_comb begin
        state_n = state;
        frame_err_n = 1'b0;
        case (state)
            INIT:       state_n = WAIT_FRAME;
            WAIT_FRAME: state_n = i_rx_started ? COLLECT : WAIT_FRAME;
            COLLECT: begin
                if (i_rx_started) begin
                    frame_err_n = 1'b1;
                end else if (i_rx_ended) begin
                    state_n = cnt_upd == 3'd6 && !err_upd ? COMMIT : WAIT_FRAME;
                    frame_err_n = !(cnt_upd == 3'd6 && !err_upd);
                end
            end
            default:    state_n = WAIT_FRAME;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt <= '0;
            err <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_level <= '0;
            o_start <= 1'b0;
            o_frame_err <= 1'b0;
            o_overflow <= 1'b0;
            o_underrun <= 1'b0;
            {o_bin0, o_vc, o_bin1} <= '0;
        end else begin
            state <= state_n;
            cnt <= restart ? 3'd0 : cnt_upd;
            err <= restart ? 1'b0 : err_upd;
            o_start <= state == INIT;
            o_frame_err <= frame_err_n;
            o_overflow <= push && full;
            o_underrun <= i_next_req && empty;
            o_level <= o_level + LW'(push_ok) - LW'(pop_ok);
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (pop_ok) {o_bin0, o_vc, o_bin1} <= mem[rd_ptr];
`ifdef IDFT_SYM_SCHED_IDLE_ZERO_EN
            else if (i_next_req) {o_bin0, o_vc, o_bin1} <= '0;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (store) begin
            if (cnt[0]) acc[base + 8 +: 2] <= i_rx_byte[1:0];
            else acc[base +: 8] <= i_rx_byte;
        end
        if (push_ok) mem[wr_ptr] <= acc;
    end
endmodule

// File: tb/tb_idft_sym_sched.sv
// tb_idft_sym_sched: scoreboard bench for idft_sym_sched (DEPTH=4); honours IDFT_SYM_SCHED_IDLE_ZERO_EN.
module tb_idft_sym_sched;
    logic clk = 1'b0;
    logic reset;
    logic i_rx_started, i_rx_byte_done, i_rx_ended, i_next_req;
    logic [7:0] i_rx_byte;
    logic o_start, o_frame_err, o_overflow, o_underrun;
    logic [9:0] o_bin0, o_vc, o_bin1;
    logic [2:0] o_level;
    logic [29:0] q[$];
    logic [29:0] last;
    int total = 0;
    int bad = 0;

    idft_sym_sched #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .i_rx_started(i_rx_started), .i_rx_byte_done(i_rx_byte_done),
        .i_rx_byte(i_rx_byte), .i_rx_ended(i_rx_ended), .i_next_req(i_next_req),
        .o_start(o_start), .o_bin0(o_bin0), .o_vc(o_vc), .o_bin1(o_bin1),
        .o_level(o_level), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow), .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] entry(input logic [63:0] v);
        return {v[9:8], v[7:0], v[25:24], v[23:16], v[41:40], v[39:32]};
    endfunction

    task automatic expect_pop(input int old);
        if (old > 0) begin
            last = q.pop_front();
            check("pop_bins", {o_bin0, o_vc, o_bin1}, last);
            check("pop_unr", o_underrun, 0);
        end else begin
`ifdef IDFT_SYM_SCHED_IDLE_ZERO_EN
            last = '0;
`endif
            check("idle_bins", {o_bin0, o_vc, o_bin1}, last);
            check("underrun", o_underrun, 1);
        end
    endtask

    task automatic pop;
        int old;
        old = q.size();
        i_next_req = 1'b1;
        tick;
        i_next_req = 1'b0;
        expect_pop(old);
        check("pop_level", o_level, q.size());
    endtask

    task automatic send_bytes(input logic [63:0] v, input int n, input bit same_end);
        for (int i = 0; i < n; i++) begin
            i_rx_byte_done = 1'b1;
            i_rx_byte = v[8*i +: 8];
            i_rx_ended = same_end && i == n - 1;
            tick;
            i_rx_byte_done = 1'b0;
            i_rx_ended = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] v, input int n, input bit same_end,
                              input bit pop_commit, input int pre);
        int old;
        if (pre > 0) begin
            i_rx_started = 1'b1;
            tick;
            i_rx_started = 1'b0;
            send_bytes(~v, pre, 1'b0);
        end
        i_rx_started = 1'b1;
        tick;
        i_rx_started = 1'b0;
        if (pre > 0) check("restart_err", o_frame_err, 1);
        send_bytes(v, n, same_end);
        if (!same_end || n == 0) begin
            i_rx_ended = 1'b1;
            tick;
            i_rx_ended = 1'b0;
        end
        check("frame_err", o_frame_err, n != 6);
        old = q.size();
        i_next_req = pop_commit;
        tick;
        i_next_req = 1'b0;
        if (pop_commit) expect_pop(old);
        if (n == 6) begin
            check("overflow", o_overflow, old == 4 && !pop_commit);
            if (old < 4) q.push_back(entry(v));
        end
        check("frame_level", o_level, q.size());
    endtask

    initial begin
        reset = 1'b0;
        {i_rx_started, i_rx_byte_done, i_rx_ended, i_next_req} = '0;
        i_rx_byte = '0;
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bins", {o_bin0, o_vc, o_bin1}, 0);
        check("rst_level", o_level, 0);
        check("rst_start", o_start, 0);
        reset = 1'b1;
        tick;
        check("start_hi", o_start, 1);
        tick;
        check("start_lo", o_start, 0);
        send_frame(64'h0000_03BC_0278_0134, 6, 0, 0, 0);
        pop;
        pop;
        send_frame({$urandom, $urandom}, 5, 0, 0, 0);
        send_frame({$urandom, $urandom}, 7, 0, 0, 0);
        send_frame({$urandom, $urandom}, 6, 0, 0, 3);
        pop;
        for (int i = 0; i < 5; i++) send_frame({$urandom, $urandom}, 6, i[0], 0, 0);
        check("full_level", o_level, 4);
        for (int i = 0; i < 5; i++) pop;
        send_frame({$urandom, $urandom}, 6, 0, 1, 0);
        send_frame({$urandom, $urandom}, 6, 1, 1, 0);
        pop;
        send_frame({$urandom, $urandom}, 6, 0, 0, 0);
        send_frame({$urandom, $urandom}, 6, 0, 0, 0);
        i_rx_started = 1'b1;
        tick;
        i_rx_started = 1'b0;
        send_bytes({$urandom, $urandom}, 3, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_bins", {o_bin0, o_vc, o_bin1}, 0);
        check("mid_rst_level", o_level, 0);
        check("mid_rst_start", o_start, 0);
        q.delete();
        last = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick;
        check("restart_hi", o_start, 1);
        tick;
        check("restart_lo", o_start, 0);
        send_frame(64'h0000_03BC_0278_0134, 6, 0, 0, 0);
        pop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
